// File: rtl/store_unload.sv
// rtl/store_unload.sv - drain-side unload controller for the load/store level path
// Optional burst beats (STEP=BURST) are compiled in with `define STORE_UNLOAD_BURST_EN.
module store_unload #(
   parameter int N     = 50000,
   parameter int CBITS = 16,
   parameter int BURST = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             full_in,
   output logic             take_valid,
   input  logic             take_ready,
   output logic [CBITS-1:0] take_count,
   output logic [CBITS-1:0] level,
   output logic             busy,
   output logic             done,
   output logic [7:0]       overrun
);

   localparam logic [CBITS-1:0] N_C = CBITS'(N);
`ifdef STORE_UNLOAD_BURST_EN
   localparam logic [CBITS-1:0] STEP_C = CBITS'(BURST);
`else
   localparam logic [CBITS-1:0] STEP_C = CBITS'(1);
`endif

   generate
      if (N < 1 || N >= (1 << CBITS) || BURST < 1 || BURST > N) begin : g_bad_params
         $error("store_unload: parameters out of range");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             full_prev_q;
   logic [CBITS-1:0] level_q, level_d;
   logic             take_valid_q, take_valid_d;
   logic [CBITS-1:0] take_count_q, take_count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       overrun_q, overrun_d;

   logic             full_ev;
   logic [CBITS-1:0] level_sub;

   function automatic logic [CBITS-1:0] beat_size(input logic [CBITS-1:0] remaining);
      return (remaining < STEP_C) ? remaining : STEP_C;
   endfunction

   assign full_ev   = full_in & ~full_prev_q;
   // take_count never exceeds level, so this cannot wrap
   assign level_sub = level_q - take_count_q;

   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      take_valid_d = take_valid_q;
      take_count_d = take_count_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      overrun_d    = overrun_q;

      if (state_q != S_IDLE && full_ev && overrun_q != 8'hFF) begin
         overrun_d = overrun_q + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            level_d      = '0;
            take_valid_d = 1'b0;
            take_count_d = '0;
            busy_d       = 1'b0;
            if (full_ev) begin
               state_d      = S_DRAIN;
               level_d      = N_C;
               take_valid_d = 1'b1;
               take_count_d = beat_size(N_C);
               busy_d       = 1'b1;
            end
         end
         S_DRAIN: begin
            if (take_valid_q && take_ready) begin
               level_d = level_sub;
               if (level_sub == '0) begin
                  state_d      = S_DONE;
                  take_valid_d = 1'b0;
                  take_count_d = '0;
                  done_d       = 1'b1;
               end else begin
                  take_count_d = beat_size(level_sub);
               end
            end
         end
         S_DONE: begin
            state_d      = S_IDLE;
            take_valid_d = 1'b0;
            take_count_d = '0;
            busy_d       = 1'b0;
         end
         default: begin
            state_d      = S_IDLE;
            level_d      = '0;
            take_valid_d = 1'b0;
            take_count_d = '0;
            busy_d       = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         full_prev_q  <= 1'b0;
         level_q      <= '0;
         take_valid_q <= 1'b0;
         take_count_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= '0;
      end else begin
         state_q      <= state_d;
         full_prev_q  <= full_in;
         level_q      <= level_d;
         take_valid_q <= take_valid_d;
         take_count_q <= take_count_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign take_valid = take_valid_q;
   assign take_count = take_count_q;
   assign level      = level_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_store_unload.sv
// tb/tb_store_unload.sv - self-checking bench for store_unload (N=8, CBITS=16, BURST=3)
// Honours STORE_UNLOAD_BURST_EN so the reference model matches the compiled beat size.
module tb_store_unload;

   localparam int N     = 8;
   localparam int CBITS = 16;
   localparam int BURST = 3;
`ifdef STORE_UNLOAD_BURST_EN
   localparam int STEP = BURST;
`else
   localparam int STEP = 1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             full_in = 1'b0;
   logic             take_ready = 1'b0;
   logic             take_valid;
   logic [CBITS-1:0] take_count;
   logic [CBITS-1:0] level;
   logic             busy;
   logic             done;
   logic [7:0]       overrun;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int lvl;
      int cnt;
   } beat_t;

   beat_t plan[$];

   store_unload #(.N(N), .CBITS(CBITS), .BURST(BURST)) dut (
      .clk       (clk),
      .rst       (rst),
      .full_in   (full_in),
      .take_valid(take_valid),
      .take_ready(take_ready),
      .take_count(take_count),
      .level     (level),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Expected beat list for one full event: each beat takes min(remaining, STEP).
   task automatic build_plan();
      int rem;
      int c;
      plan.delete();
      rem = N;
      while (rem > 0) begin
         c = (rem < STEP) ? rem : STEP;
         plan.push_back('{lvl: rem, cnt: c});
         rem -= c;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      full_in = 1'b0;
      take_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      full_in = 1'b0;
      take_ready = 1'b1;
      @(negedge clk);
      full_in = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({take_valid, take_count, level, busy, done, overrun} !== 43'd0)
         begin errors++; $display("FAIL reset_async: outputs=%h required=0", {take_valid, take_count, level, busy, done, overrun}); end
      full_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({take_valid, take_count, level, busy, done, overrun} !== 43'd0)
            begin errors++; $display("FAIL reset_hold[%0d]: outputs=%h required=0", i, {take_valid, take_count, level, busy, done, overrun}); end
      end
   endtask

   task automatic test_basic_drain();
      int  beats = 0;
      bit  ended = 0;
      build_plan();
      take_ready = 1'b1;
      full_in = 1'b0;
      @(negedge clk);
      full_in = 1'b1;
      for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            checks++;
            if (take_valid !== 1'b1 || busy !== 1'b1)
               begin errors++; $display("FAIL drain_latency: valid=%b busy=%b required 1 1", take_valid, busy); end
         end
         if (take_valid) begin
            checks++;
            if (beats >= plan.size() || level !== CBITS'(plan[beats].lvl) || take_count !== CBITS'(plan[beats].cnt))
               begin errors++; $display("FAIL drain_beat[%0d]: level=%0d count=%0d", beats, level, take_count); end
            beats++;
         end else begin
            ended = 1;
         end
      end
      checks++;
      if (beats != plan.size())
         begin errors++; $display("FAIL drain_beats: got=%0d required=%0d", beats, plan.size()); end
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || level !== '0)
         begin errors++; $display("FAIL drain_done: done=%b busy=%b level=%0d required 1 1 0", done, busy, level); end
      full_in = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || take_valid !== 1'b0)
         begin errors++; $display("FAIL drain_idle: done=%b busy=%b valid=%b required 0 0 0", done, busy, take_valid); end
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int stall = 3;
      bit ended = 0;
      build_plan();
      take_ready = 1'b1;
      full_in = 1'b0;
      @(negedge clk);
      full_in = 1'b1;
      for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
         @(negedge clk);
         if (!take_valid) begin
            if (idx > 0) ended = 1;
         end else begin
            checks++;
            if (idx >= plan.size() || level !== CBITS'(plan[idx].lvl) || take_count !== CBITS'(plan[idx].cnt))
               begin errors++; $display("FAIL bp_beat[%0d] stall=%0d: level=%0d count=%0d", idx, stall, level, take_count); end
            if (idx == 2 && stall > 0) begin
               take_ready = 1'b0;
               stall--;
            end else begin
               take_ready = 1'b1;
               idx++;
            end
         end
      end
      checks++;
      if (idx != plan.size() || stall != 0)
         begin errors++; $display("FAIL bp_total: beats=%0d stall_left=%0d required %0d 0", idx, stall, plan.size()); end
      full_in = 1'b0;
      take_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_overrun();
      int  beats = 0;
      bit  ended = 0;
      do_reset();
      build_plan();
      take_ready = 1'b0;
      @(negedge clk);
      full_in = 1'b1;
      for (int c = 1; c < 60 && !ended; c++) begin
         @(negedge clk);
         if (done) begin
            ended = 1;
         end else begin
            full_in = (c == 2 || c >= 4);
            take_ready = (c >= 6);
            if (take_valid && take_ready) beats++;
         end
      end
      checks++;
      if (!ended || beats != plan.size() || overrun !== 8'd2)
         begin errors++; $display("FAIL overrun_drain: ended=%b beats=%0d overrun=%0d required 1 %0d 2", ended, beats, overrun, plan.size()); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (take_valid !== 1'b0 || busy !== 1'b0 || overrun !== 8'd2)
            begin errors++; $display("FAIL overrun_held[%0d]: valid=%b busy=%b overrun=%0d required 0 0 2", i, take_valid, busy, overrun); end
      end
      full_in = 1'b0;
      @(negedge clk);
      full_in = 1'b1;
      @(negedge clk);
      checks++;
      if (take_valid !== 1'b1 || level !== CBITS'(N))
         begin errors++; $display("FAIL overrun_restart: valid=%b level=%0d required 1 %0d", take_valid, level, N); end
      take_ready = 1'b1;
      full_in = 1'b0;
      ended = 0;
      for (int c = 0; c < 40 && !ended; c++) begin
         @(negedge clk);
         if (done) ended = 1;
      end
      checks++;
      if (!ended) begin errors++; $display("FAIL overrun_redrain: done not seen within 40 cycles"); end
   endtask

   task automatic test_overrun_saturate();
      bit ended = 0;
      do_reset();
      take_ready = 1'b0;
      @(negedge clk);
      full_in = 1'b1;
      @(negedge clk);
      full_in = 1'b0;
      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         full_in = 1'b1;
         @(negedge clk);
         full_in = 1'b0;
         if (i == 253) begin
            checks++;
            if (overrun !== 8'd254)
               begin errors++; $display("FAIL sat_below: overrun=%0d required 254", overrun); end
         end
      end
      checks++;
      if (overrun !== 8'd255 || level !== CBITS'(N) || take_valid !== 1'b1)
         begin errors++; $display("FAIL sat_top: overrun=%0d level=%0d valid=%b required 255 %0d 1", overrun, level, take_valid, N); end
      take_ready = 1'b1;
      for (int c = 0; c < 40 && !ended; c++) begin
         @(negedge clk);
         if (done) ended = 1;
      end
      checks++;
      if (!ended || overrun !== 8'd255)
         begin errors++; $display("FAIL sat_drain: ended=%b overrun=%0d required 1 255", ended, overrun); end
   endtask

   task automatic test_mid_reset();
      bit hit = 0;
      int target;
      build_plan();
      target = plan[plan.size() / 2].lvl;
      do_reset();
      take_ready = 1'b1;
      @(negedge clk);
      full_in = 1'b1;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk);
         if (take_valid && level == CBITS'(target)) hit = 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL midrst_reach: level %0d never seen", target); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (take_valid !== 1'b0 || level !== '0 || busy !== 1'b0)
         begin errors++; $display("FAIL midrst_async: valid=%b level=%0d busy=%b required 0 0 0", take_valid, level, busy); end
      full_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (take_valid !== 1'b0 || level !== '0 || busy !== 1'b0)
         begin errors++; $display("FAIL midrst_idle: valid=%b level=%0d busy=%b required 0 0 0", take_valid, level, busy); end
      full_in = 1'b1;
      @(negedge clk);
      checks++;
      if (take_valid !== 1'b1 || level !== CBITS'(N) || take_count !== CBITS'(plan[0].cnt))
         begin errors++; $display("FAIL midrst_restart: valid=%b level=%0d count=%0d required 1 %0d %0d", take_valid, level, take_count, N, plan[0].cnt); end
      full_in = 1'b0;
      hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk);
         if (done) hit = 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL midrst_drain: done not seen within 40 cycles"); end
   endtask

   // Random full/ready traffic against a transaction-level model of the unload.
   task automatic test_random();
      beat_t         mq[$];
      bit            m_done = 0;
      bit            m_prev = 0;
      int            m_ovr = 0;
      bit            ev;
      logic [42:0]   exp_out;
      logic [42:0]   act_out;
      do_reset();
      build_plan();
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (mq.size() > 0)
            exp_out = {1'b1, CBITS'(mq[0].cnt), CBITS'(mq[0].lvl), 1'b1, 1'b0, 8'(m_ovr)};
         else if (m_done)
            exp_out = {1'b0, CBITS'(0), CBITS'(0), 1'b1, 1'b1, 8'(m_ovr)};
         else
            exp_out = {1'b0, CBITS'(0), CBITS'(0), 1'b0, 1'b0, 8'(m_ovr)};
         act_out = {take_valid, take_count, level, busy, done, overrun};
         checks++;
         if (act_out !== exp_out)
            begin errors++; $display("FAIL random[%0d]: outputs=%h required=%h", cyc, act_out, exp_out); end
         if ($urandom_range(0, 4) == 0) full_in = ~full_in;
         take_ready = ($urandom_range(0, 2) != 0);
         ev = full_in & ~m_prev;
         m_prev = full_in;
         if (mq.size() > 0) begin
            if (ev && m_ovr < 255) m_ovr++;
            if (take_ready) begin
               void'(mq.pop_front());
               if (mq.size() == 0) m_done = 1;
            end
         end else if (m_done) begin
            if (ev && m_ovr < 255) m_ovr++;
            m_done = 0;
         end else if (ev) begin
            mq = plan;
         end
      end
      full_in = 1'b0;
      take_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      test_reset();
      test_basic_drain();
      test_backpressure();
      test_overrun();
      test_overrun_saturate();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_unload.md
# store_unload

Drain-side controller for the load/store level path. It watches the producer's full indication and, once the store reaches N, unloads the stored volume to a downstream sink through a valid/ready handshake. It tracks the remaining level, signals completion, and counts full indications that arrive while an unload is still in progress. It sits directly downstream of the load/store filler, taking the filler's `sig` output on `full_in`.

## Interface
Parameters:
- `N`, 50000: volume unloaded per full event; 1 ≤ N < 2^CBITS.
- `CBITS`, 16: width of the level and count datapaths.
- `BURST`, 16: units per handshake when burst mode is compiled in; 1 ≤ BURST ≤ N.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `full_in`  in  1  store-full level from the filler.
- `take_valid`  out  1  unload beat offered.
- `take_ready`  in  1  sink accepts the beat.
- `take_count`  out  CBITS  units carried by the current beat.
- `level`  out  CBITS  volume still to unload.
- `busy`  out  1  high in DRAIN and DONE.
- `done`  out  1  one-cycle pulse when level reaches 0.
- `overrun`  out  8  saturating count of ignored full events.

## Operation
- Edge detect: a `full_prev` register samples `full_in` every cycle in every state. A full event is `full_in & ~full_prev`.
- **IDLE**: `level`=0, `take_valid`=0, `take_count`=0. A full event moves to DRAIN with `level`←N.
- **DRAIN**:
  - `take_valid`=1 and `take_count`=min(`level`, STEP). STEP is 1, or BURST when burst mode is compiled in.
  - On `take_valid & take_ready`, `level` ← `level` − `take_count`.
  - If the new level is 0, move to DONE. Otherwise stay in DRAIN.
- **DONE**: `take_valid`=0 and `done`=1 for exactly one cycle, then move to IDLE.
- Stability: while `take_valid`=1 and `take_ready`=0, `take_count` and `level` hold.
- Overrun: a full event in DRAIN or DONE does not restart the unload. It increments `overrun`, which saturates at 255 and never wraps.
- Held level: if `full_in` stays high through DONE, IDLE does not restart. A fresh 0→1 transition is required.
- Arithmetic: the min() compare is unsigned on CBITS bits. Subtraction cannot underflow because `take_count` ≤ `level`.
- Reset values: state IDLE, `full_prev`=0, `level`=0, `take_valid`=0, `take_count`=0, `busy`=0, `done`=0, `overrun`=0.

## Timing
- Full event sampled at edge k → `take_valid`=1, `level`=N, `busy`=1 after edge k.
- Beat accepted at edge m with a resulting level of 0 → after edge m: `take_valid`=0, `done`=1, state DONE. After edge m+1: `done`=0, `busy`=0, state IDLE.
- A new full event can first be accepted at edge m+2.
- Throughput: one beat per cycle with `take_ready` held high. N beats without burst mode; ceil(N/BURST) beats with it.
- Reset mid-operation: `rst` low clears all state and outputs asynchronously; `take_valid` drops without waiting for a clock. The partially unloaded volume is discarded and the block restarts in IDLE.
- Reset release is synchronous to `clk`; the integrator provides the release synchronizer.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `STORE_UNLOAD_BURST_EN`.
- Defined: STEP=BURST, so each beat carries min(`level`, BURST) units and the last beat carries the remainder.
- Undefined: STEP=1, so `take_count` is constant 1 in DRAIN and 0 elsewhere, and the `BURST` parameter is unused.

## Test plan
Bench settings: N=8, CBITS=16.
- Reset: drive `rst`=0 mid-clock → all outputs 0 immediately, and they stay 0 for 5 cycles after release with `full_in`=0.
- Basic drain (macro undefined, `take_ready`=1):
  - Stimulus: `full_in` 0→1.
  - Response: `take_valid` high for 8 cycles with `level` 8,7,…,1 and `take_count`=1, then `done` for one cycle, then `busy`=0.
- Backpressure: `take_ready`=0 for 3 cycles after the 2nd beat → `level`=6 and `take_count`=1 held all 3 cycles, with no lost or duplicated beat; total beats = 8.
- Overrun:
  - Stimulus: pulse `full_in` 0→1 twice during DRAIN, then hold `full_in`=1 after `done`.
  - Response: `overrun`=2 and drain length unchanged at 8; no restart until `full_in` goes 0→1 again.
- Burst (macro defined, BURST=3) → `take_count` 3,3,2 and `level` 8,5,2, then `done`.
- Mid-drain reset: assert `rst` at `level`=4, then release → `take_valid`=0 and `level`=0, state IDLE; the next full event restarts with `level`=8.
